// File: rtl/ev_hash_engine_param.sv
// ev_hash_engine_param
//
// Toeplitz error-verification hash over a corrected key. Random bits are
// streamed word by word from a read-only BRAM; each returning word is paired
// with its predecessor to form a 2W-bit window from which every key bit of
// the older word selects a TAG_W-bit slice to XOR into the accumulator.
// An optional compare against the peer tag is reported with done.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           request a hash (accepted only in IDLE)
//   abort           cancel a running hash
//   mode_compare    sampled at start; 1 = compare tag against peer_tag
//   rb_base_addr    first BRAM word address, sampled at start
//   key_in          corrected key, held stable by the source while busy
//   peer_tag        peer hash tag used for the compare
//   busy            high from the cycle after start acceptance to done/abort
//   hashtag         computed tag, held between runs
//   done            one-cycle pulse, hashtag valid
//   match/mismatch  compare result, valid only with done
//   rb_addr/rb_en   BRAM read address (registered) and enable
//   rb_dout         BRAM read data, RD_LAT cycles after the address
//
// Handshake: there is no back-pressure. A request is taken on any cycle with
// start=1 while the FSM is in IDLE; completion is the single-cycle done pulse.
// The internal FSM state is available as the signal 'state' for observation.
module ev_hash_engine_param #(
  parameter int KEY_LEN = 32768,
  parameter int W       = 64,
  parameter int TAG_W   = 64,
  parameter int ADDR_W  = 14,
  parameter int RD_LAT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               mode_compare,
  input  logic [ADDR_W-1:0]  rb_base_addr,
  input  logic [KEY_LEN-1:0] key_in,
  input  logic [TAG_W-1:0]   peer_tag,
  output logic               busy,
  output logic [TAG_W-1:0]   hashtag,
  output logic               done,
  output logic               match,
  output logic               mismatch,
  output logic [ADDR_W-1:0]  rb_addr,
  output logic               rb_en,
  input  logic [W-1:0]       rb_dout
);

  localparam int NW = KEY_LEN / W;
  localparam int CW = $clog2(NW + 2);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_next;

  logic [CW-1:0]     icnt;       // read addresses issued so far
  logic [CW-1:0]     rcnt;       // words returned so far
  logic [RD_LAT-1:0] vld;        // marks the returning word of each read
  logic [W-1:0]      prev_word;  // lower half of the window
  logic [TAG_W-1:0]  acc;
  logic [TAG_W-1:0]  acc_next;
  logic              mode_q;

  logic              accept;
  logic              arrive;
  logic              last;
  logic [CW-1:0]     key_idx;
  logic [W-1:0]      key_word;
  logic [2*W-1:0]    window;

  assign accept  = (state == IDLE) && start;
  assign busy    = (state == READ) || (state == DRAIN);
  assign rb_en   = (state == READ);
  assign arrive  = vld[RD_LAT-1];
  // The word that arrives when rcnt == NW is the final one (index NW).
  assign last    = arrive && (rcnt == CW'(NW));
  // Word rcnt arriving completes the window for key word rcnt-1.
  assign key_idx = rcnt - CW'(1);

  always_comb begin
    window   = {rb_dout, prev_word};
    key_word = key_in[int'(key_idx) * W +: W];
    acc_next = acc;
    for (int b = 0; b < W; b++) begin
      if (key_word[b]) begin
        acc_next = acc_next ^ window[b +: TAG_W];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = READ;
      READ: begin
        if (abort)                   state_next = IDLE;
        else if (icnt == CW'(NW))    state_next = DRAIN;
      end
      DRAIN: begin
        if (abort)                   state_next = IDLE;
        else if (last)               state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address generation, return tracking and accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_addr   <= '0;
      icnt      <= '0;
      rcnt      <= '0;
      vld       <= '0;
      prev_word <= '0;
      acc       <= '0;
      mode_q    <= 1'b0;
      hashtag   <= '0;
      done      <= 1'b0;
      match     <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      done     <= 1'b0;
      match    <= 1'b0;
      mismatch <= 1'b0;
      if (accept) begin
        rb_addr <= rb_base_addr;
        icnt    <= '0;
        rcnt    <= '0;
        vld     <= '0;
        acc     <= '0;
        mode_q  <= mode_compare;
      end else if (busy && abort) begin
        // Drop in-flight returns; hashtag keeps its previous value.
        vld  <= '0;
        rcnt <= '0;
      end else begin
        if (rb_en && (icnt != CW'(NW))) begin
          rb_addr <= rb_addr + ADDR_W'(1);
          icnt    <= icnt + CW'(1);
        end
        vld <= (vld << 1) | RD_LAT'(rb_en);
        if (arrive) begin
          prev_word <= rb_dout;
          rcnt      <= rcnt + CW'(1);
          // The first word only primes the window.
          if (rcnt != '0) acc <= acc_next;
          if (last) begin
            hashtag  <= acc_next;
            done     <= 1'b1;
            match    <= mode_q && (acc_next == peer_tag);
            mismatch <= mode_q && (acc_next != peer_tag);
          end
        end
      end
    end
  end

endmodule
